mem_output_h: RTL
=================

// Module: mem_output_h
// PURPOSE
// - Capture buffer for LSTM forward-pass result vectors (one WIDTH*NUM word per iteration).
// - Write side: the LSTM top pushes one packed vector per iteration.
// - Read side: an addressed, registered port drains results to the backprop stage or testbench.
// - Write-side counterpart of the input-vector ROM; it uses the same packing and iteration indexing.
// PARAMETERS
// - WIDTH           32   bits per element (signed fixed point, not interpreted here)
// - NUM             68   elements per vector (packed, element 0 in bits [WIDTH-1:0])
// - NUM_ITERATIONS  8    vectors stored (depth)
// - CNT_W           clog2(NUM_ITERATIONS+1)   width of count output
// PORTS
// - clk          in   1              rising-edge clock
// - rst          in   1              synchronous, active-high reset
// - clr          in   1              synchronous restart of write pointer (new sequence)
// - wr_en        in   1              write request, data valid this cycle
// - wr_data      in   WIDTH*NUM      signed packed vector to store
// - wr_ready     out  1              buffer can accept a write this cycle
// - full         out  1              NUM_ITERATIONS vectors stored
// - overflow     out  1              sticky: wr_en seen while full
// - count        out  CNT_W          vectors stored since rst/clr
// - rd_addr      in   WIDTH          iteration index to read
// - rd_en        in   1              read request
// - rd_data      out  WIDTH*NUM      signed registered read data
// - rd_valid     out  1              rd_data holds the response to the previous cycle's rd_en
// BEHAVIOUR
// - Reset (rst=1 at edge): count=0, full=0, overflow=0, rd_data=0, rd_valid=0.
//   Storage array is NOT cleared.
// - wr_ready = !full (combinational from registered full).
// - Write accepted iff wr_en && !full && !clr && !rst:
//   - mem[count] <= wr_data; count <= count+1.
//   - full <= 1 when count+1 == NUM_ITERATIONS.
// - wr_en while full: data dropped, count unchanged, overflow <= 1 (sticky until rst/clr).
// - clr: count=0, full=0, overflow=0 next cycle; contents retained.
//   clr + wr_en in the same cycle: clr wins, write dropped, no overflow.
// - rst has priority over clr; both dominate writes.
// - Read latency is 1 cycle:
//   - rd_en at edge N gives rd_data = mem[rd_addr] and rd_valid = 1 after edge N+1.
//   - rd_en=0: rd_valid <= 0 and rd_data holds its last value.
// - rd_addr >= NUM_ITERATIONS (any upper bits set): rd_data <= 0, rd_valid <= 1.
// - Read and write to the same address in the same cycle: read-first, returns the old contents.
// - Reading a slot not written since rst: returns whatever the array holds (X in sim).
//   The bench must not check it.
// - No state machine beyond pointer/flags.
//   States are implied by count: EMPTY (0), FILLING (1..N-1), FULL (N).
//   Transitions occur only on accepted write, clr or rst.
// - rd_data is declared signed; no arithmetic is performed in this block.
// STRUCTURE
// - Shared header/package: default WIDTH/NUM/NUM_ITERATIONS and the clog2 function,
//   shared with mem_input_x users and the LSTM top.
// - One sub-module: vec_ram_1w1r.
//   - Simple dual-port, read-first, registered read.
//   - Parameters WIDTH*NUM data width and NUM_ITERATIONS depth.
//   - Pointer, flags and address range check live in mem_output_h.
// - Expected size 120-200 lines RTL.
// TESTING
// - Fill: rst, then 8 writes with wr_data = {NUM{32'h0000_0100*i}} for i=0..7.
//   - count steps 1..8; full=1 after 8th edge; wr_ready=0.
//   - Reading addr 3 gives all elements 32'h0000_0300 one cycle later.
// - Overflow: continue from the full state with wr_en=1 and data 32'hDEAD_BEEF.
//   - overflow=1, count stays 8.
//   - Read addr 7 still gives 32'h0000_0700.
// - Collision: count=2, wr_en with data A at slot 2, rd_en with rd_addr=2 in the same cycle.
//   - rd_data = old slot-2 contents.
//   - Next cycle rd_addr=2 returns A.
// - clr vs write: clr=1 and wr_en=1 in the same cycle.
//   - count=0, full=0, overflow=0.
//   - Slot 0 unchanged on readback.
// - Out-of-range / latency: rd_addr=32'h0000_0008, then 32'hFFFF_FFFF.
//   - rd_data=0 and rd_valid=1, each exactly 1 cycle after rd_en.
//   - rd_en=0 in the following cycle gives rd_valid=0.
// - Reset mid-fill: rst after 5 writes.
//   - count=0 and flags=0.
//   - Slot 4 readback still returns its written value.

Source files
------------

// File: rtl/mem_output_h_pkg.sv
// ============================================================================
// Module  : mem_output_h_pkg
// Brief   : Shared LSTM vector-buffer defaults and clog2 helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_output_h_pkg;

    localparam int c_DEF_WIDTH          = 32;
    localparam int c_DEF_NUM            = 68;
    localparam int c_DEF_NUM_ITERATIONS = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Address width that never collapses to zero bits for a depth of one.
    function automatic int addr_w(input int depth);
        return (clog2(depth) > 0) ? clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_output_h_vec_ram_1w1r.sv
// ============================================================================
// Module  : vec_ram_1w1r
// Brief   : Simple dual-port RAM, read-first, registered read with sync clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vec_ram_1w1r
    import mem_output_h_pkg::*;
#(
    parameter int DW    = c_DEF_WIDTH * c_DEF_NUM,
    parameter int DEPTH = c_DEF_NUM_ITERATIONS,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic          i_rzero,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Same-edge write is not yet visible here, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rzero ? '0 : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mem_output_h.sv
// ============================================================================
// Module  : mem_output_h
// Brief   : Capture buffer for LSTM forward-pass result vectors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_output_h
    import mem_output_h_pkg::*;
#(
    parameter int WIDTH          = c_DEF_WIDTH,
    parameter int NUM            = c_DEF_NUM,
    parameter int NUM_ITERATIONS = c_DEF_NUM_ITERATIONS,
    parameter int CNT_W          = clog2(NUM_ITERATIONS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          wr_en,
    input  logic signed [WIDTH*NUM-1:0]   wr_data,
    output logic                          wr_ready,
    output logic                          full,
    output logic                          overflow,
    output logic        [CNT_W-1:0]       count,
    input  logic        [WIDTH-1:0]       rd_addr,
    input  logic                          rd_en,
    output logic signed [WIDTH*NUM-1:0]   rd_data,
    output logic                          rd_valid
);

    localparam int c_AW = addr_w(NUM_ITERATIONS);

    logic [CNT_W-1:0]     r_count;
    logic                 r_full;
    logic                 r_overflow;
    logic                 r_rd_valid;
    logic                 w_wr_accept;
    logic                 w_rd_in_range;
    logic [WIDTH*NUM-1:0] w_rdata;

    assign w_wr_accept   = wr_en && !r_full && !clr && !rst;
    assign w_rd_in_range = (rd_addr < WIDTH'(NUM_ITERATIONS));

    // Fill level is implied by r_count: 0 empty, NUM_ITERATIONS full.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (wr_en) begin
            if (r_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + CNT_W'(1);
                r_full  <= (r_count + CNT_W'(1)) == CNT_W'(NUM_ITERATIONS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
        end
    end

    vec_ram_1w1r #(
        .DW    (WIDTH * NUM),
        .DEPTH (NUM_ITERATIONS),
        .AW    (c_AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_accept),
        .i_waddr (r_count[c_AW-1:0]),
        .i_wdata (wr_data),
        .i_re    (rd_en),
        .i_rzero (!w_rd_in_range),
        .i_raddr (rd_addr[c_AW-1:0]),
        .o_rdata (w_rdata)
    );

    assign wr_ready = !r_full;
    assign full     = r_full;
    assign overflow = r_overflow;
    assign count    = r_count;
    assign rd_data  = w_rdata;
    assign rd_valid = r_rd_valid;

endmodule

`default_nettype wire
